// File: rtl/wb_decoder.sv
// wb_decoder: pipelined Wishbone address decoder with in-order port locking, unmapped-port errors and an ack watchdog
module wb_decoder #(
    parameter int NPORTS = 8,
    parameter int AWIDTH = 32,
    parameter int BASE = 28,
    parameter logic [NPORTS-1:0] PORT_MASK = {NPORTS{1'b1}},
    parameter int MAXOUT = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   m_cyc,
    input  logic                   m_stb,
    input  logic                   m_we,
    input  logic [3:0]             m_sel,
    input  logic [AWIDTH-1:0]      m_adr,
    input  logic [31:0]            m_dat_w,
    output logic [31:0]            m_dat_r,
    output logic                   m_ack,
    output logic                   m_err,
    output logic                   m_stall,
    output logic [NPORTS-1:0]      s_cyc,
    output logic [NPORTS-1:0]      s_stb,
    output logic                   s_we,
    output logic [3:0]             s_sel,
    output logic [AWIDTH-1:0]      s_adr,
    output logic [31:0]            s_dat_w,
    input  logic [32*NPORTS-1:0]   s_dat_r,
    input  logic [NPORTS-1:0]      s_ack,
    input  logic [NPORTS-1:0]      s_err,
    input  logic [NPORTS-1:0]      s_stall,
    output logic                   timeout
);
    localparam int SELW = NPORTS > 1 ? $clog2(NPORTS) : 1;
    localparam int NP2 = 1 << SELW;
    localparam int CW = $clog2(MAXOUT + 1);
    localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0]   cnt;
    logic [SELW-1:0] cur;
    logic [SELW-1:0] dp;
    logic            err_pend;
    logic [WW-1:0]   wdog;
    logic [NP2-1:0]  mask_x, ack_x, err_x, stall_x, stb_x, cyc_x;
    logic            busy, mapped, can_issue, accept, err_accept, ret;

    // Per-port vectors padded to a power of two so any select value indexes safely
    assign mask_x  = NP2'(PORT_MASK);
    assign ack_x   = NP2'(s_ack);
    assign err_x   = NP2'(s_err);
    assign stall_x = NP2'(s_stall);

    assign dp     = m_adr[BASE +: SELW];
    assign mapped = mask_x[dp];
    assign busy   = cnt != '0;

    assign timeout = TIMEOUT > 0 && busy && wdog == WW'(TIMEOUT);

    // No new issue in the watchdog cycle: the burst is being dropped
    assign can_issue = m_cyc && m_stb && !err_pend && !timeout &&
                       (!busy || (dp == cur && cnt < CW'(MAXOUT)));

    assign stb_x = (can_issue && mapped) ? NP2'(1) << dp : '0;
    assign cyc_x = (m_cyc && busy) ? NP2'(1) << cur : '0;
    assign s_stb = stb_x[NPORTS-1:0];
    assign s_cyc = s_stb | cyc_x[NPORTS-1:0];

    assign accept     = can_issue && mapped && !stall_x[dp];
    assign err_accept = can_issue && !mapped;
    assign ret        = busy && (ack_x[cur] || err_x[cur]);

    assign m_stall = m_cyc && m_stb && (!can_issue || (mapped && stall_x[dp]));
    assign m_ack   = busy && ack_x[cur];
    assign m_err   = (busy && err_x[cur]) || err_pend || timeout;
    assign m_dat_r = s_dat_r[{cur, 5'd0} +: 32];

    assign s_we    = m_we;
    assign s_sel   = m_sel;
    assign s_adr   = m_adr;
    assign s_dat_w = m_dat_w;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            cur      <= '0;
            err_pend <= 1'b0;
            wdog     <= '0;
        end else begin
            if (accept)
                cur <= dp;
            err_pend <= err_accept;
            if (!m_cyc || timeout)
                cnt <= '0;
            else if (accept != ret)
                cnt <= accept ? cnt + 1'b1 : cnt - 1'b1;
            wdog <= (TIMEOUT == 0 || !m_cyc || timeout || accept || ret || !busy) ? '0 : wdog + 1'b1;
        end
    end
endmodule

// File: doc/wb_decoder.md
Name: wb_decoder

Overview:
- Parametrised Wishbone (pipelined, B4) address decoder connecting one bus master to NPORTS slave ports.
- Successor to the fixed-port MMU used for the CPU instruction, data and I/O buses. Port count, select-field position, and the set of mapped ports are generalised.
- Adds behaviour the MMU lacks: outstanding-transaction tracking, in-order port locking, error response for unmapped ports, and a per-transaction ack watchdog.
- Sits between a CPU or sub-bus master and RAM/peripheral slaves. Instances can cascade, for example an I/O sub-decoder behind a main decoder.

Parameters:
- NPORTS, 8: number of slave ports; SELW = clog2(NPORTS).
- AWIDTH, 32: master address width.
- BASE, 28: lowest bit of the port-select field; port = m_adr[BASE+SELW-1:BASE].
- PORT_MASK, {NPORTS{1'b1}}: bit p = 1 means port p is mapped.
- MAXOUT, 4: maximum outstanding (accepted, un-acked) requests; counter width clog2(MAXOUT+1).
- TIMEOUT, 1023: cycles without an ack before the watchdog fires; 0 disables the watchdog.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- m_cyc, m_stb, m_we, in, 1 each: master cycle, strobe, write.
- m_sel, in, 4: master byte selects.
- m_adr, in, AWIDTH: master address.
- m_dat_w, in, 32: master write data.
- m_dat_r, out, 32: read data returned to the master.
- m_ack, m_err, m_stall, out, 1 each: master ack, error, stall.
- s_cyc, s_stb, out, NPORTS: per-port cycle and strobe.
- s_we, s_sel, s_adr, s_dat_w, out, 1/4/AWIDTH/32: broadcast copies of the master signals.
- s_dat_r, in, 32*NPORTS: slave read data; port p occupies bits [32p+31:32p].
- s_ack, s_err, s_stall, in, NPORTS: per-port ack, error, stall.
- timeout, out, 1: one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values: cnt = 0, cur = 0, err_pend = 0, wdog = 0, timeout = 0.
- Combinational outputs with all inputs idle: s_cyc = 0, s_stb = 0, m_ack = 0, m_err = 0, m_stall = 0.
- Registered state:
  - cnt: outstanding-request counter.
  - cur: locked port.
  - err_pend: pending error flag.
  - wdog: watchdog counter.
- Decode is combinational: dp = select field of m_adr; mapped = PORT_MASK[dp].
- States:
  - IDLE (cnt = 0, !err_pend).
  - BUSY (cnt > 0; cur locked).
  - ERR (err_pend = 1).
- can_issue = m_cyc & m_stb & !err_pend & (cnt == 0 | (dp == cur & cnt < MAXOUT)).
- Mapped request:
  - s_stb[dp] = can_issue & mapped.
  - m_stall = !can_issue | s_stall[dp].
  - Accept = s_stb[dp] & !s_stall[dp]. On accept: cur <= dp.
- Unmapped request:
  - Accepted only in IDLE; m_stall = 0 in IDLE, m_stall = 1 in BUSY.
  - On accept: err_pend <= 1, so m_err = 1 exactly one cycle later.
  - err_pend then clears, giving one error per request; cnt is unchanged.
- s_cyc[p] = m_cyc & ((cnt > 0 & p == cur) | s_stb[p]); at most one bit is set.
- Broadcast outputs follow the master combinationally: s_we = m_we, s_sel = m_sel, s_adr = m_adr, s_dat_w = m_dat_w.
- Return path (combinational, qualified by cnt > 0):
  - m_ack = s_ack[cur].
  - m_dat_r = s_dat_r[cur]; this value is don't-care when m_ack = 0.
  - m_err = s_err[cur] | err_pend | timeout.
- Slave ack or err arriving when cnt = 0 is ignored.
- Counter update: cnt <= cnt + accept - (s_ack[cur] | s_err[cur]).
  - Simultaneous accept and ack leaves cnt unchanged.
  - cnt saturates at neither end: the issue gating prevents overflow and the cnt > 0 qualification prevents underflow.
- Watchdog (TIMEOUT > 0):
  - wdog is cleared on any accept, ack, err, or when cnt = 0; otherwise it increments while cnt > 0.
  - When wdog == TIMEOUT: timeout = 1 for one cycle, cnt <= 0, wdog <= 0.
  - That cycle drives m_err = 1 once for the whole burst; the remaining outstanding requests are dropped. s_cyc[cur] falls on the next cycle.
- m_cyc deassertion in any state:
  - cnt <= 0, err_pend <= 0, wdog <= 0 on the next edge.
  - s_cyc drops combinationally in the same cycle.
  - Late slave acks are ignored because cnt = 0.
- Asserting rst_i mid-transaction clears all state immediately (asynchronously); no ack or err is emitted.
- Latency: zero added cycles on the request path and on the return path.

Test Plan:
- Read, port 5, BASE = 28, m_adr = 32'h5000_0010: s_stb = 8'h20, one cycle; slave acks with 32'hDEADBEEF two cycles later -> m_ack = 1 and m_dat_r = 32'hDEADBEEF in the same cycle; cnt returns to 0.
- Pipelined burst of 4 reads to port 7, slave never stalls: 4 consecutive accepts; cnt peaks at 4; a 5th strobe sees m_stall = 1 until the first ack; 4 acks are returned in order.
- Port switch: port 5 with cnt = 2, then a request to port 3 -> m_stall = 1 and s_stb[3] = 0 until both port-5 acks arrive; port 3 issues on the following cycle.
- Unmapped port, PORT_MASK = 8'hA8, request to port 1 -> m_stall = 0, no s_stb, m_err = 1 exactly one cycle later, m_ack stays 0.
- Watchdog, TIMEOUT = 15, request to port 5 never acked -> timeout and m_err pulse 16 cycles after the accept; cnt = 0; s_cyc[5] low on the next cycle; a subsequent request proceeds normally.
- m_cyc dropped with cnt = 3, followed by a stray s_ack[5] -> m_ack stays 0, cnt = 0; asserting rst_i mid-burst clears all outputs within the same cycle.
